// File: rtl/vga_scanline_stage.sv
// Output video stage: two-stage registered RGB/sync pipeline with CRT-style
// scanline dimming on odd lines and internal line counting from the syncs.
module vga_scanline_stage #(
  parameter int DW       = 6,
  parameter int SYNC_POL = 0,
  parameter int LW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [1:0]    scan_mode,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          line_odd,
  output logic [LW-1:0] line_num,
  output logic [1:0]    mode_act
);

  localparam logic ACT   = 1'(SYNC_POL);
  localparam logic INACT = ~ACT;

  // Stage 1 holds the incoming pixel plus the sync history for edge detection.
  logic [DW-1:0] r1, g1, b1;
  logic          hs1, vs1, hs_prev, vs_prev;

  logic          hs_edge, vs_edge;
  logic          odd_nxt;
  logic [LW-1:0] num_nxt;
  logic [1:0]    mode_nxt;

  function automatic logic [DW-1:0] dim(input logic [DW-1:0] x,
                                        input logic [1:0]    m,
                                        input logic          odd);
    logic [DW-1:0] y;
    y = x;
    if (odd) begin
      case (m)
        2'b01:   y = x - (x >> 2);
        2'b10:   y = x >> 1;
        2'b11:   y = '0;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  // Line/frame bookkeeping; vsync assertion wins over a coincident hsync one.
  always_comb begin
    hs_edge  = (hs1 == ACT) && (hs_prev != ACT);
    vs_edge  = (vs1 == ACT) && (vs_prev != ACT);
    odd_nxt  = line_odd;
    num_nxt  = line_num;
    mode_nxt = mode_act;
    if (vs_edge) begin
      odd_nxt  = 1'b0;
      num_nxt  = '0;
      mode_nxt = scan_mode;
    end else if (hs_edge) begin
      odd_nxt = ~line_odd;
      if (line_num != {LW{1'b1}}) num_nxt = line_num + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1       <= '0;
      g1       <= '0;
      b1       <= '0;
      hs1      <= INACT;
      vs1      <= INACT;
      hs_prev  <= INACT;
      vs_prev  <= INACT;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      hs_out   <= INACT;
      vs_out   <= INACT;
      line_odd <= 1'b0;
      line_num <= '0;
      mode_act <= 2'b00;
    end else if (ce) begin
      r1       <= r_in;
      g1       <= g_in;
      b1       <= b_in;
      hs1      <= hs_in;
      vs1      <= vs_in;
      hs_prev  <= hs1;
      vs_prev  <= vs1;
      // Dimming sees the line parity as updated by this same cycle's edges.
      r_out    <= dim(r1, mode_nxt, odd_nxt);
      g_out    <= dim(g1, mode_nxt, odd_nxt);
      b_out    <= dim(b1, mode_nxt, odd_nxt);
      hs_out   <= hs1;
      vs_out   <= vs1;
      line_odd <= odd_nxt;
      line_num <= num_nxt;
      mode_act <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_vga_scanline_stage.sv
// Bench for vga_scanline_stage: directed vector table, hand sequences for
// ce gating and counter saturation, then random stimulus against a model.
module tb_vga_scanline_stage;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst, ce, hs_in, vs_in;
  logic [DW-1:0] r_in, g_in, b_in;
  logic [1:0]    scan_mode;

  logic [DW-1:0] r_out, g_out, b_out;
  logic          hs_out, vs_out, line_odd;
  logic [9:0]    line_num;
  logic [1:0]    mode_act;

  logic [DW-1:0] s_r, s_g, s_b;
  logic          s_hs, s_vs, s_odd;
  logic [3:0]    s_num;
  logic [1:0]    s_mode;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vga_scanline_stage #(.DW(DW), .SYNC_POL(0), .LW(10)) u_dut (
    .clk(clk), .rst(rst), .ce(ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .scan_mode(scan_mode),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out),
    .line_odd(line_odd), .line_num(line_num), .mode_act(mode_act)
  );

  vga_scanline_stage #(.DW(DW), .SYNC_POL(0), .LW(4)) u_sat (
    .clk(clk), .rst(rst), .ce(ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .scan_mode(scan_mode),
    .r_out(s_r), .g_out(s_g), .b_out(s_b),
    .hs_out(s_hs), .vs_out(s_vs),
    .line_odd(s_odd), .line_num(s_num), .mode_act(s_mode)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit rs, input bit c, input int r, input int g, input int b,
                       input bit h, input bit v, input int m);
    @(negedge clk);
    rst = rs; ce = c;
    r_in = DW'(r); g_in = DW'(g); b_in = DW'(b);
    hs_in = h; vs_in = v; scan_mode = 2'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int r, input int g, input int b,
                         input bit h, input bit v, input bit odd, input int num, input int mode);
    chk({tag, ".r"}, int'(r_out), r);
    chk({tag, ".g"}, int'(g_out), g);
    chk({tag, ".b"}, int'(b_out), b);
    chk({tag, ".hs"}, int'(hs_out), int'(h));
    chk({tag, ".vs"}, int'(vs_out), int'(v));
    chk({tag, ".odd"}, int'(line_odd), int'(odd));
    chk({tag, ".num"}, int'(line_num), num);
    chk({tag, ".mode"}, int'(mode_act), mode);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int r, g, b; bit hs, vs; int mode;
    int er, eg, eb; bit ehs, evs, eodd; int enm, emode;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input int r, g, b, input bit hs, vs, input int mode,
                         input int er, eg, eb, input bit ehs, evs, eodd,
                         input int enm, emode);
    vec_t v;
    v = '{r, g, b, hs, vs, mode, er, eg, eb, ehs, evs, eodd, enm, emode};
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [DW-1:0] r, g, b; logic hs, vs; } samp_t;
  samp_t hist[$];
  samp_t m_out;
  bit    m_odd;
  int    m_cnt, m_mode;

  function automatic int dim_ref(input int x, input int mode, input bit odd);
    if (!odd || mode == 0) return x;
    case (mode)
      1:       return x - x / 4;
      2:       return x / 2;
      default: return 0;
    endcase
  endfunction

  // Active sync level is 0; a line/frame begins where a sample is active and
  // the one accepted before it was not. Output is the sample two accepts back.
  task automatic model_step(input bit rs, input bit c, input samp_t s, input int sm);
    samp_t cur, prv, blank;
    blank = '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1};
    if (rs) begin
      hist = {blank, blank};
      m_out = blank; m_odd = 0; m_cnt = 0; m_mode = 0;
    end else if (c) begin
      cur = hist[$];
      prv = hist[$-1];
      if (cur.vs == 1'b0 && prv.vs == 1'b1) begin
        m_odd = 0; m_cnt = 0; m_mode = sm;
      end else if (cur.hs == 1'b0 && prv.hs == 1'b1) begin
        m_odd = !m_odd; m_cnt++;
      end
      m_out.r  = DW'(dim_ref(int'(cur.r), m_mode, m_odd));
      m_out.g  = DW'(dim_ref(int'(cur.g), m_mode, m_odd));
      m_out.b  = DW'(dim_ref(int'(cur.b), m_mode, m_odd));
      m_out.hs = cur.hs;
      m_out.vs = cur.vs;
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  initial begin
    rst = 1; ce = 1; r_in = '0; g_in = '0; b_in = '0;
    hs_in = 1; vs_in = 1; scan_mode = 2'b00;

    // Reset with ce=1 and random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 1, 1, 0, 0, 0);
    end

    // Passthrough latency, frame timing with 75%, mode stability, coincident edges.
    add_vec(17, 42, 63, 1, 1, 0,   0,  0,  0, 1, 1, 0, 0, 0);
    add_vec( 0,  0,  0, 1, 1, 0,  17, 42, 63, 1, 1, 0, 0, 0);
    add_vec(63, 63, 63, 1, 0, 1,   0,  0,  0, 1, 1, 0, 0, 0);
    add_vec(63, 63, 63, 1, 1, 1,  63, 63, 63, 1, 0, 0, 0, 1);
    add_vec(63, 63, 63, 0, 1, 1,  63, 63, 63, 1, 1, 0, 0, 1);
    add_vec(63, 63, 63, 1, 1, 1,  48, 48, 48, 0, 1, 1, 1, 1);
    add_vec(63, 63, 63, 1, 1, 1,  48, 48, 48, 1, 1, 1, 1, 1);
    add_vec(63, 63, 63, 0, 1, 1,  48, 48, 48, 1, 1, 1, 1, 1);
    add_vec(63, 63, 63, 1, 1, 1,  63, 63, 63, 0, 1, 0, 2, 1);
    add_vec(63, 63, 63, 1, 1, 1,  63, 63, 63, 1, 1, 0, 2, 1);
    add_vec(63, 63, 63, 0, 1, 1,  63, 63, 63, 1, 1, 0, 2, 1);
    add_vec(63, 63, 63, 1, 1, 1,  48, 48, 48, 0, 1, 1, 3, 1);
    add_vec(63, 63, 63, 1, 1, 3,  48, 48, 48, 1, 1, 1, 3, 1);
    add_vec(63, 63, 63, 0, 1, 3,  48, 48, 48, 1, 1, 1, 3, 1);
    add_vec(63, 63, 63, 1, 1, 3,  63, 63, 63, 0, 1, 0, 4, 1);
    add_vec(63, 63, 63, 1, 0, 3,  63, 63, 63, 1, 1, 0, 4, 1);
    add_vec(63, 63, 63, 1, 1, 3,  63, 63, 63, 1, 0, 0, 0, 3);
    add_vec(63, 63, 63, 0, 1, 3,  63, 63, 63, 1, 1, 0, 0, 3);
    add_vec(63, 63, 63, 1, 1, 3,   0,  0,  0, 0, 1, 1, 1, 3);
    add_vec(63, 63, 63, 0, 0, 2,   0,  0,  0, 1, 1, 1, 1, 3);
    add_vec(63, 63, 63, 1, 1, 2,  63, 63, 63, 0, 0, 0, 0, 2);
    add_vec(63, 63, 63, 1, 1, 2,  63, 63, 63, 1, 1, 0, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, 1, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, tbl[i].vs, tbl[i].mode);
      chk_all($sformatf("vec%0d", i), tbl[i].er, tbl[i].eg, tbl[i].eb,
              tbl[i].ehs, tbl[i].evs, tbl[i].eodd, tbl[i].enm, tbl[i].emode);
      chk($sformatf("vec%0d.sat_num", i), int'(s_num), tbl[i].enm);
    end

    // ce gating: outputs frozen while ce=0, then data resumes in order.
    drive(0, 1, 5, 6, 7, 1, 1, 2);
    chk_all("gate_pre", 63, 63, 63, 1, 1, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      chk_all($sformatf("gate_hold%0d", i), 63, 63, 63, 1, 1, 0, 0, 2);
    end
    drive(0, 1, 9, 10, 11, 1, 1, 2);
    chk_all("gate_resume0", 5, 6, 7, 1, 1, 0, 0, 2);
    drive(0, 1, 0, 0, 0, 1, 1, 2);
    chk_all("gate_resume1", 9, 10, 11, 1, 1, 0, 0, 2);

    // Saturation: 20 hs pulses without vs.
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 0, 0, 0, 0, 1, 2);
      drive(0, 1, 0, 0, 0, 1, 1, 2);
      chk($sformatf("sat%0d.num4", i), int'(s_num), (i > 15) ? 15 : i);
      chk($sformatf("sat%0d.odd4", i), int'(s_odd), i % 2);
      chk($sformatf("sat%0d.num10", i), int'(line_num), i);
      chk($sformatf("sat%0d.odd10", i), int'(line_odd), i % 2);
    end

    // Random stimulus against the model, starting from a reset.
    for (int i = 0; i < 3000; i++) begin
      bit rs, c, h, v;
      int r, g, b, m;
      samp_t s;
      rs = (i == 0) || ($urandom_range(0, 399) == 0);
      c  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 63);
      g  = $urandom_range(0, 63);
      b  = $urandom_range(0, 63);
      h  = ($urandom_range(0, 5) != 0);
      v  = ($urandom_range(0, 40) != 0);
      m  = $urandom_range(0, 3);
      s  = '{r: DW'(r), g: DW'(g), b: DW'(b), hs: h, vs: v};
      drive(rs, c, r, g, b, h, v, m);
      model_step(rs, c, s, m);
      chk_all($sformatf("rnd%0d", i), int'(m_out.r), int'(m_out.g), int'(m_out.b),
              m_out.hs, m_out.vs, m_odd, (m_cnt > 1023) ? 1023 : m_cnt, m_mode);
      chk($sformatf("rnd%0d.sat_num", i), int'(s_num), (m_cnt > 15) ? 15 : m_cnt);
      chk($sformatf("rnd%0d.sat_odd", i), int'(s_odd), int'(m_odd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
